// File: rtl/ebpf_alu_pkg.sv
// Shared eBPF ALU definitions: divider FSM states, iteration counts, opcode constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ebpf_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam int DIV_ITER_64 = 64;
    localparam int DIV_ITER_32 = 32;
    localparam int DIV_CNT_W   = 7;

    // ALU opcode field values; the decoder maps these onto is_mod.
    localparam logic [3:0] BPF_DIV = 4'h3;
    localparam logic [3:0] BPF_MOD = 4'h9;

endpackage

// File: rtl/div_trial_sub.sv
// One restoring-division step: trial subtract of divisor from the shifted remainder.
// Latency: combinational.
// Backpressure: none; ports rem (WIDTH+1), divisor (WIDTH) in; diff (WIDTH+1), borrow out.
module div_trial_sub #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   diff,
    output logic             borrow
);

    logic [WIDTH+1:0] full_diff;

    // One extra bit on top turns the borrow into a plain sign bit.
    always_comb begin
        full_diff = {1'b0, rem} - {2'b00, divisor};
    end

    assign diff   = full_diff[WIDTH:0];
    assign borrow = full_diff[WIDTH+1];

endmodule

// File: rtl/ebpf_div_mod_unit.sv
// Multi-cycle unsigned DIV/MOD (ALU64/ALU32), restoring division, one quotient bit per clock.
// Latency: accept -> out_valid after 64 (ALU64) / 32 (ALU32) RUN cycles; divide-by-zero goes straight to DONE.
// Backpressure: in_ready only in IDLE; result and out_valid held in DONE until out_ready.
module ebpf_div_mod_unit
    import ebpf_alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_mod,
    input  logic             alu32,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int HALF = WIDTH / 2;

    div_state_e state_q, state_d;

    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                 is_mod_q, is_mod_d;
    logic                 alu32_q, alu32_d;

    logic [WIDTH-1:0]     dvd_m, dvs_m, quo_load;
    logic [DIV_CNT_W-1:0] last_cnt;
    logic                 accept, dvs_zero, last_step;

    logic [WIDTH:0]       step_rem, trial_diff;
    logic                 trial_borrow, trial_ok;
    logic [WIDTH-1:0]     rem_step, quo_step;

    // Operands masked per mode. In ALU32 the dividend is parked in the upper
    // half of quo so its MSB is the first to shift out; after 32 steps the
    // upper half has filled with zeros and the low half holds the quotient.
    always_comb begin
        dvd_m    = alu32 ? {{HALF{1'b0}}, dividend[HALF-1:0]} : dividend;
        dvs_m    = alu32 ? {{HALF{1'b0}}, divisor[HALF-1:0]}  : divisor;
        quo_load = alu32 ? {dividend[HALF-1:0], {HALF{1'b0}}} : dividend;
        dvs_zero = (dvs_m == '0);
        accept   = (state_q == ST_IDLE) && in_valid;
        last_cnt = alu32_q ? DIV_CNT_W'(DIV_ITER_32 - 1) : DIV_CNT_W'(DIV_ITER_64 - 1);
        last_step = (cnt_q == last_cnt);
    end

    // {rem, quo} shifted left by one: quo MSB (next dividend bit) enters rem.
    assign step_rem = {rem_q, quo_q[WIDTH-1]};

    div_trial_sub #(
        .WIDTH (WIDTH)
    ) u_trial (
        .rem     (step_rem),
        .divisor (dvs_q),
        .diff    (trial_diff),
        .borrow  (trial_borrow)
    );

    // Keep the trial only if it fits the remainder register; with rem < divisor
    // a no-borrow result always does, so this is the usual borrow test.
    always_comb begin
        trial_ok = ~trial_borrow & ~trial_diff[WIDTH];
        rem_step = trial_ok ? trial_diff[WIDTH-1:0] : step_rem[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], trial_ok};
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = dvs_zero ? ST_DONE : ST_RUN;
            ST_RUN:  if (last_step) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        is_mod_d = is_mod_q;
        alu32_d  = alu32_q;
        if (accept) begin
            quo_d    = quo_load;
            rem_d    = '0;
            dvs_d    = dvs_m;
            cnt_d    = '0;
            is_mod_d = is_mod;
            alu32_d  = alu32;
            // eBPF divide by zero: DIV -> 0, MOD -> (masked) dividend.
            if (dvs_zero) result_d = is_mod ? dvd_m : '0;
        end else if (state_q == ST_RUN) begin
            quo_d = quo_step;
            rem_d = rem_step;
            cnt_d = cnt_q + DIV_CNT_W'(1);
            if (last_step) result_d = is_mod_q ? rem_step : quo_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            is_mod_q <= 1'b0;
            alu32_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            is_mod_q <= is_mod_d;
            alu32_q  <= alu32_d;
        end
    end

    // Outputs decoded from state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN:  busy = 1'b1;
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign result = result_q;

endmodule
